// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-bit FIFO write-side framer.
// Holds the frame state encoding, the default start-of-frame byte and the byte width.
package fifo_pkg;

  localparam int         BYTE_W      = 8;
  localparam logic [7:0] SOF_DEFAULT = 8'h7E;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } frame_state_t;

endpackage

// File: rtl/fifo_byte_framer.sv
// fifo_byte_framer: splits multi-byte input words into framed bytes written to
// the async FIFO write port. Each frame starts with SOF_BYTE and ends after the
// payload of the word flagged in_last.
// Optional feature macro: FRAME_CHECKSUM_EN appends an XOR checksum byte
// (state CHK) after the last payload byte of every frame.
module fifo_byte_framer
  import fifo_pkg::*;
#(
  parameter int         WORD_BYTES = 4,
  parameter logic [7:0] SOF_BYTE   = SOF_DEFAULT,
  parameter int         COUNT_W    = 16
) (
  input  logic                          write_clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [8*WORD_BYTES-1:0]       in_data,
  input  logic [$clog2(WORD_BYTES):0]   in_keep,
  input  logic                          in_last,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [7:0]                    fifo_data,
  output logic                          busy,
  output logic [COUNT_W-1:0]            frame_count
);

  localparam int KEEP_W = $clog2(WORD_BYTES) + 1;
  localparam int IDX_W  = $clog2(WORD_BYTES);

  frame_state_t                  state_r;
  frame_state_t                  state_n_s;
  logic                          in_frame_r;
  logic [8*WORD_BYTES-1:0]       hold_data_r;
  logic [IDX_W-1:0]              last_idx_r;
  logic                          hold_last_r;
  logic [IDX_W-1:0]              index_r;
  logic [COUNT_W-1:0]            frame_count_r;
  logic [IDX_W-1:0]              keep_idx_s;
  logic                          accept_s;
  logic                          write_s;
  logic [7:0]                    data_s;
  logic                          byte_last_s;
  logic                          frame_done_s;
  logic [7:0]                    cur_byte_s;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]                    checksum_r;
`endif

  assign accept_s    = in_valid && (state_r == IDLE);
  assign byte_last_s = (index_r == last_idx_r);
  assign cur_byte_s  = hold_data_r[int'(index_r) * BYTE_W +: BYTE_W];

  // Normalise the byte count: 0 or an over-range value means a full word.
  always_comb begin
    keep_idx_s = IDX_W'(WORD_BYTES - 1);
    if ((in_keep == {KEEP_W{1'b0}}) || (in_keep > KEEP_W'(WORD_BYTES))) begin
      keep_idx_s = IDX_W'(WORD_BYTES - 1);
    end else begin
      keep_idx_s = IDX_W'(in_keep - KEEP_W'(1));
    end
  end

  // Next-state and FIFO write-port decode; writes are gated by fifo_full.
  always_comb begin
    state_n_s = state_r;
    write_s   = 1'b0;
    data_s    = 8'h00;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n_s = in_frame_r ? DATA : HDR;
        end else begin
          state_n_s = IDLE;
        end
      end
      HDR: begin
        write_s = !fifo_full;
        data_s  = SOF_BYTE;
        if (write_s) begin
          state_n_s = DATA;
        end else begin
          state_n_s = HDR;
        end
      end
      DATA: begin
        write_s = !fifo_full;
        data_s  = cur_byte_s;
        if (write_s && byte_last_s) begin
`ifdef FRAME_CHECKSUM_EN
          state_n_s = hold_last_r ? CHK : IDLE;
`else
          state_n_s = IDLE;
`endif
        end else begin
          state_n_s = DATA;
        end
      end
      CHK: begin
`ifdef FRAME_CHECKSUM_EN
        write_s = !fifo_full;
        data_s  = checksum_r;
        if (write_s) begin
          state_n_s = IDLE;
        end else begin
          state_n_s = CHK;
        end
`else
        state_n_s = IDLE;
`endif
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

`ifdef FRAME_CHECKSUM_EN
  assign frame_done_s = (state_r == CHK) && write_s;
`else
  assign frame_done_s = (state_r == DATA) && write_s && byte_last_s && hold_last_r;
`endif

  assign in_ready      = (state_r == IDLE);
  assign fifo_write_en = write_s;
  assign fifo_data     = data_s;
  assign busy          = (state_r != IDLE) || in_frame_r;
  assign frame_count   = frame_count_r;

  // Frame state register.
  always_ff @(posedge write_clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Word capture, byte index, frame flag and completed-frame counter.
  always_ff @(posedge write_clk or negedge reset) begin
    if (!reset) begin
      hold_data_r   <= {(8*WORD_BYTES){1'b0}};
      last_idx_r    <= {IDX_W{1'b0}};
      hold_last_r   <= 1'b0;
      index_r       <= {IDX_W{1'b0}};
      in_frame_r    <= 1'b0;
      frame_count_r <= {COUNT_W{1'b0}};
    end else begin
      if (accept_s) begin
        hold_data_r <= in_data;
        last_idx_r  <= keep_idx_s;
        hold_last_r <= in_last;
        index_r     <= {IDX_W{1'b0}};
        in_frame_r  <= 1'b1;
      end else if ((state_r == DATA) && write_s && !byte_last_s) begin
        index_r <= index_r + IDX_W'(1);
      end
      if (frame_done_s) begin
        in_frame_r    <= 1'b0;
        frame_count_r <= frame_count_r + COUNT_W'(1);
      end
    end
  end

`ifdef FRAME_CHECKSUM_EN
  // Running XOR of written payload bytes, restarted by each SOF write.
  always_ff @(posedge write_clk or negedge reset) begin
    if (!reset) begin
      checksum_r <= 8'h00;
    end else if ((state_r == HDR) && write_s) begin
      checksum_r <= 8'h00;
    end else if ((state_r == DATA) && write_s) begin
      checksum_r <= checksum_r ^ cur_byte_s;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_byte_framer.sv
// Scoreboard bench for fifo_byte_framer: expected FIFO bytes are queued when a
// word is issued; a negedge monitor pops and compares on every fifo_write_en.
module tb_fifo_byte_framer;

  logic        write_clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  in_keep;
  logic        in_last;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [7:0]  fifo_data;
  logic        busy;
  logic [15:0] frame_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  fifo_byte_framer #(.WORD_BYTES(4), .SOF_BYTE(8'h7E), .COUNT_W(16)) dut (
    .write_clk(write_clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .fifo_full(fifo_full),
    .fifo_write_en(fifo_write_en), .fifo_data(fifo_data), .busy(busy),
    .frame_count(frame_count)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every FIFO write must match the head of the expected queue.
  always @(negedge write_clk) begin
    if (fifo_full) begin
      checks++;
      if (fifo_write_en) begin
        errors++;
        $display("FAIL write_while_full: got write_en=1 expected 0");
      end
    end
    if (fifo_write_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got %0h expected no write", fifo_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (fifo_data !== e) begin
          errors++;
          $display("FAIL fifo_byte: got %0h expected %0h", fifo_data, e);
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] k, input logic l);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (in_ready) ok = 1'b1;
      @(posedge write_clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (exp_q.size() == 0 && in_ready) done = 1'b1;
      else begin
        @(posedge write_clk);
        #1;
      end
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int low_cnt;
    reset = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_keep = 3'd0;
    in_last = 1'b0; fifo_full = 1'b0;
    repeat (2) @(posedge write_clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_write_en", {31'd0, fifo_write_en}, 32'd0);
    check("rst_fifo_data", {24'd0, fifo_data}, 32'd0);
    check("rst_frame_count", {16'd0, frame_count}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    @(posedge write_clk);
    #1;

    // Single-word frame; measure in_ready-low duration.
    push(8'h7E); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
`ifdef FRAME_CHECKSUM_EN
    push(8'h44);
`endif
    send_word(32'h44332211, 3'd4, 1'b1);
    low_cnt = 0;
    for (int c = 0; c < 50 && !in_ready; c++) begin
      low_cnt++;
      @(posedge write_clk);
      #1;
    end
`ifdef FRAME_CHECKSUM_EN
    check("ready_low_cycles", low_cnt, 32'd6);
`else
    check("ready_low_cycles", low_cnt, 32'd5);
`endif
    wait_drain("drain_single");
    check("count_single", {16'd0, frame_count}, 32'd1);
    check("busy_idle", {31'd0, busy}, 32'd0);

    // Two-word frame: single SOF.
    push(8'h7E); push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD); push(8'hEE);
`ifdef FRAME_CHECKSUM_EN
    push(8'hEE);
`endif
    send_word(32'hDDCCBBAA, 3'd4, 1'b0);
    check("busy_mid", {31'd0, busy}, 32'd1);
    send_word(32'h000000EE, 3'd1, 1'b1);
    wait_drain("drain_two_word");
    check("count_two_word", {16'd0, frame_count}, 32'd2);

    // Stall for 3 cycles at DATA index 2.
    push(8'h7E); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
`ifdef FRAME_CHECKSUM_EN
    push(8'h04);
`endif
    send_word(32'h04030201, 3'd4, 1'b1);
    repeat (3) @(posedge write_clk);
    #1;
    fifo_full = 1'b1;
    #1;
    for (int c = 0; c < 3; c++) begin
      check("stall_write_en", {31'd0, fifo_write_en}, 32'd0);
      check("stall_data", {24'd0, fifo_data}, 32'h03);
      @(posedge write_clk);
      #1;
    end
    fifo_full = 1'b0;
    wait_drain("drain_stall");
    check("count_stall", {16'd0, frame_count}, 32'd3);

    // keep=0 means whole word.
    push(8'h7E); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
`ifdef FRAME_CHECKSUM_EN
    push(8'h04);
`endif
    send_word(32'h04030201, 3'd0, 1'b1);
    wait_drain("drain_keep0");
    check("count_keep0", {16'd0, frame_count}, 32'd4);

    // keep=5 (over range) means whole word.
    push(8'h7E); push(8'h0D); push(8'h0C); push(8'h0B); push(8'h0A);
`ifdef FRAME_CHECKSUM_EN
    push(8'h00);
`endif
    send_word(32'h0A0B0C0D, 3'd5, 1'b1);
    wait_drain("drain_keep5");
    check("count_keep5", {16'd0, frame_count}, 32'd5);

    // keep=2 partial word.
    push(8'h7E); push(8'h66); push(8'h77);
`ifdef FRAME_CHECKSUM_EN
    push(8'h11);
`endif
    send_word(32'h99887766, 3'd2, 1'b1);
    wait_drain("drain_keep2");
    check("count_keep2", {16'd0, frame_count}, 32'd6);

    // Reset during DATA index 1: only 7E,55 reach the FIFO.
    push(8'h7E); push(8'h55);
    send_word(32'h88776655, 3'd4, 1'b1);
    repeat (2) @(posedge write_clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_write_en", {31'd0, fifo_write_en}, 32'd0);
    check("midrst_count", {16'd0, frame_count}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_queue", exp_q.size(), 32'd0);
    @(posedge write_clk);
    #1;
    reset = 1'b1;
    @(posedge write_clk);
    #1;

    // Fresh frame after reset starts with SOF.
    push(8'h7E); push(8'h11); push(8'h22); push(8'h33); push(8'h44);
`ifdef FRAME_CHECKSUM_EN
    push(8'h44);
`endif
    send_word(32'h44332211, 3'd4, 1'b1);
    wait_drain("drain_after_rst");
    check("count_after_rst", {16'd0, frame_count}, 32'd1);

    repeat (3) @(posedge write_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
